// File: rtl/io_input_port_if.sv
// LSU-side bus for the input-port register window: the LSU drives address and write
// strobe/data, and the port answers with read data and a hit flag.
interface io_input_port_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (output addr, we, wdata, input  rdata, hit);
  modport slave  (input  addr, we, wdata, output rdata, hit);
endinterface

// File: rtl/io_input_port.sv
// MMIO read-side responder for board switches and buttons: synchronised switches,
// debounced buttons and sticky write-1-to-clear press events with a registered irq.
module io_input_port #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_7800,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 16,
  parameter logic        BTN_ACT_LOW = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [31:0]           i_io_sw,
  input  logic [3:0]            i_io_btn,
  io_input_port_if.slave        lsu,
  output logic                  o_btn_irq
);

  localparam int unsigned    CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DB_CYCLES - 1);
  localparam logic [29:0]    SW_WORD  = BASE_ADDR[31:2];
  localparam logic [29:0]    BTN_WORD = SW_WORD + 30'd4;
  localparam logic [29:0]    EVT_WORD = SW_WORD + 30'd5;

  logic [SYNC_STAGES-1:0][31:0] sw_sync;
  logic [SYNC_STAGES-1:0][3:0]  btn_sync;
  logic [3:0]                   btn_s;
  logic [3:0]                   btn_db, btn_db_next;
  logic [3:0][CW-1:0]           cnt, cnt_next;
  logic [3:0]                   evt, evt_next, evt_clr;
  logic [29:0]                  word;
  logic                         unused_bits;

  assign word        = lsu.addr[31:2];
  assign unused_bits = &{1'b0, lsu.addr[1:0], lsu.wdata[31:4]};

  // Index 0 is the first stage; the last index feeds the rest of the design.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_sync  <= '0;
      btn_sync <= '0;
    end else begin
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], i_io_sw};
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], i_io_btn};
    end
  end

  assign btn_s = btn_sync[SYNC_STAGES-1] ^ {4{BTN_ACT_LOW}};

  always_comb begin
    btn_db_next = btn_db;
    cnt_next    = cnt;
    for (int unsigned i = 0; i < 4; i++) begin
      if (btn_s[i] == btn_db[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        btn_db_next[i] = btn_s[i];
        cnt_next[i]    = '0;
      end else begin
        cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  // A rising debounced edge is ORed in after the clear so a coincident W1C cannot lose it.
  always_comb begin
    evt_clr  = (lsu.we && (word == EVT_WORD)) ? lsu.wdata[3:0] : '0;
    evt_next = (evt & ~evt_clr) | (btn_db_next & ~btn_db);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_db    <= '0;
      cnt       <= '0;
      evt       <= '0;
      o_btn_irq <= 1'b0;
    end else begin
      btn_db    <= btn_db_next;
      cnt       <= cnt_next;
      evt       <= evt_next;
      o_btn_irq <= |evt;
    end
  end

  always_comb begin
    lsu.hit   = 1'b0;
    lsu.rdata = '0;
    if (word == SW_WORD) begin
      lsu.hit   = 1'b1;
      lsu.rdata = sw_sync[SYNC_STAGES-1];
    end else if (word == BTN_WORD) begin
      lsu.hit   = 1'b1;
      lsu.rdata = {28'b0, btn_db};
    end else if (word == EVT_WORD) begin
      lsu.hit   = 1'b1;
      lsu.rdata = {28'b0, evt};
    end
  end

endmodule
